// File: rtl/mole_scheduler.sv
// Mole placement scheduler: alternates pseudo-random placement waves and full retraction on mole_clk rising edges.
// A wave commits NUM_MOLES distinct holes (or fewer at the MAX_TRIES cap); hits remove moles one at a time.
module mole_scheduler #(
  parameter int          NUM_HOLES = 18,
  parameter int          NUM_MOLES = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          MAX_TRIES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_in_progress,
  input  logic                 mole_clk,
  input  logic [NUM_HOLES-1:0] hit_mask,
  output logic [NUM_HOLES-1:0] mole_positions,
  output logic                 placing,
  output logic [7:0]           wave_count
);

  localparam int                   PW  = $clog2(NUM_MOLES + 1);
  localparam int                   TW  = $clog2(MAX_TRIES + 1);
  localparam logic [PW-1:0]        NM  = PW'(NUM_MOLES);
  localparam logic [TW-1:0]        MT  = TW'(MAX_TRIES);
  localparam logic [8:0]           NH  = 9'(NUM_HOLES);
  localparam logic [NUM_HOLES-1:0] ONE = NUM_HOLES'(1);

  typedef enum logic {IDLE, PLACE} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_HOLES-1:0] pos_q, pos_d;
  logic [NUM_HOLES-1:0] shadow_q, shadow_d;
  logic [PW-1:0]        placed_q, placed_d;
  logic [TW-1:0]        tries_q, tries_d;
  logic [7:0]           wave_q, wave_d;
  logic                 placing_q, placing_d;
  logic                 mole_clk_d_q, mole_clk_d_d;
  logic [8:0]           cand;
  logic [NUM_HOLES-1:0] cand_oh;
  logic                 mclk_rise;

  always_comb begin
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    cand         = {1'b0, lfsr_q[7:0]} % NH;
    cand_oh      = ONE << cand;
    mole_clk_d_d = mole_clk;
    mclk_rise    = mole_clk & ~mole_clk_d_q;

    state_d  = state_q;
    pos_d    = pos_q;
    shadow_d = shadow_q;
    placed_d = placed_q;
    tries_d  = tries_q;
    wave_d   = wave_q;

    case (state_q)
      IDLE: begin
        if (!game_in_progress) begin
          pos_d = '0;
        end else if (mclk_rise) begin
          // An empty board means up phase, even if it was emptied by hits.
          if (pos_q != '0) begin
            pos_d = '0;
          end else begin
            shadow_d = '0;
            placed_d = '0;
            tries_d  = '0;
            state_d  = PLACE;
          end
        end else begin
          pos_d = pos_q & ~hit_mask;
        end
      end
      PLACE: begin
        pos_d = '0;
        if (!game_in_progress) begin
          state_d = IDLE;
        end else begin
          tries_d = tries_q + TW'(1);
          if ((shadow_q & cand_oh) == '0) begin
            shadow_d = shadow_q | cand_oh;
            placed_d = placed_q + PW'(1);
          end
          if (placed_d == NM || tries_d == MT) begin
            pos_d   = shadow_d;
            wave_d  = (wave_q == 8'hFF) ? wave_q : wave_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    placing_d = (state_d == PLACE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      pos_q        <= '0;
      shadow_q     <= '0;
      placed_q     <= '0;
      tries_q      <= '0;
      wave_q       <= '0;
      placing_q    <= 1'b0;
      mole_clk_d_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      pos_q        <= pos_d;
      shadow_q     <= shadow_d;
      placed_q     <= placed_d;
      tries_q      <= tries_d;
      wave_q       <= wave_d;
      placing_q    <= placing_d;
      mole_clk_d_q <= mole_clk_d_d;
    end
  end

  assign mole_positions = pos_q;
  assign placing        = placing_q;
  assign wave_count     = wave_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler: default 3-of-18 instance against an LFSR placement model,
// plus an 18-of-18 instance for the try cap, wave_count saturation and asynchronous reset.
module tb_mole_scheduler;

  localparam int NH = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, game, mclk;
  logic [NH-1:0] hit, pos;
  logic          placing;
  logic [7:0]    wc;

  logic          rst2, game2, mclk2;
  logic [NH-1:0] hit2, pos2;
  logic          placing2;
  logic [7:0]    wc2;

  int n_checks = 0;
  int n_errors = 0;

  mole_scheduler u_dut (
    .clk(clk), .rst(rst), .game_in_progress(game), .mole_clk(mclk),
    .hit_mask(hit), .mole_positions(pos), .placing(placing), .wave_count(wc)
  );

  mole_scheduler #(.NUM_HOLES(18), .NUM_MOLES(18), .LFSR_SEED(16'hACE1), .MAX_TRIES(64)) u_full (
    .clk(clk), .rst(rst2), .game_in_progress(game2), .mole_clk(mclk2),
    .hit_mask(hit2), .mole_positions(pos2), .placing(placing2), .wave_count(wc2)
  );

  function automatic logic [15:0] lstep(input logic [15:0] l);
    if (l[0]) return (l >> 1) ^ 16'hB400;
    return l >> 1;
  endfunction

  // Reference placement: walks the LFSR from the value seen in the first PLACE cycle.
  function automatic void model_place(input logic [15:0] l0, input int nm,
                                      output logic [NH-1:0] mask, output int k);
    logic [15:0] l;
    int cnt;
    int c;
    l = l0;
    cnt = 0;
    mask = '0;
    k = 0;
    for (int j = 1; j <= 64; j++) begin
      c = int'(l[7:0]) % NH;
      if (!mask[c]) begin
        mask[c] = 1'b1;
        cnt++;
      end
      if (cnt == nm || j == 64) begin
        k = j;
        break;
      end
      l = lstep(l);
    end
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= lstep(m_lfsr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises mole_clk for `hold` cycles starting an up phase, checks the resulting wave.
  task automatic wave_up(input int hold, output logic [NH-1:0] exp_mask);
    int k;
    int cnt;
    int el;
    logic extra;
    mclk = 1'b1;
    tick();
    el = 1;
    if (el >= hold) mclk = 1'b0;
    model_place(m_lfsr, 3, exp_mask, k);
    cnt = 0;
    while (placing === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
      el++;
      if (el >= hold) mclk = 1'b0;
    end
    chk("place_len", 32'(cnt), 32'(k));
    chk("place_min3", 32'(cnt >= 3), 32'd1);
    chk("wave_mask", 32'(pos), 32'(exp_mask));
    chk("wave_pop", 32'($countones(pos)), 32'd3);
    extra = 1'b0;
    while (el < hold) begin
      tick();
      el++;
      if (placing !== 1'b0) extra = 1'b1;
    end
    if (hold > 1) chk("held_edge_once", 32'(extra), 32'd0);
    mclk = 1'b0;
    tick();
  endtask

  logic [NH-1:0] e, p, low, emp;
  int maxk, cnt2;
  logic popbad, downbad, zerobad;

  initial begin
    rst = 1'b1; game = 1'b0; mclk = 1'b0; hit = '0;
    rst2 = 1'b1; game2 = 1'b0; mclk2 = 1'b0; hit2 = '0;
    tick();
    tick();
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_placing", 32'(placing), 32'd0);
    chk("rst_wc", 32'(wc), 32'd0);
    rst = 1'b0;
    rst2 = 1'b0;
    tick();
    tick();
    chk("idle_placing", 32'(placing), 32'd0);

    game = 1'b1;
    tick();
    wave_up(1, e);
    chk("wc_1", 32'(wc), 32'd1);

    p = pos;
    low = p & (~p + 18'd1);
    hit = low;
    tick();
    hit = '0;
    chk("hit_lowest", 32'(pos), 32'(p & ~low));
    chk("hit_pop2", 32'($countones(pos)), 32'd2);

    p = pos;
    emp = '0;
    for (int i = NH - 1; i >= 0; i--) if (!p[i]) emp = '0 | (18'd1 << i);
    hit = emp;
    tick();
    hit = '0;
    chk("hit_empty", 32'(pos), 32'(p));

    mclk = 1'b1;
    tick();
    mclk = 1'b0;
    chk("down_clear", 32'(pos), 32'd0);
    chk("down_noplace", 32'(placing), 32'd0);
    tick();

    wave_up(1, e);
    chk("wc_2", 32'(wc), 32'd2);

    hit = pos;
    tick();
    hit = '0;
    chk("hit_all", 32'(pos), 32'd0);
    wave_up(10, e);
    chk("wc_3", 32'(wc), 32'd3);

    p = pos;
    hit = p & (~p + 18'd1);
    mclk = 1'b1;
    tick();
    hit = '0;
    mclk = 1'b0;
    chk("edge_beats_hit", 32'(pos), 32'd0);
    tick();

    mclk = 1'b1;
    tick();
    mclk = 1'b0;
    chk("abort_in_place", 32'(placing), 32'd1);
    tick();
    game = 1'b0;
    tick();
    chk("abort_placing", 32'(placing), 32'd0);
    chk("abort_pos", 32'(pos), 32'd0);
    chk("abort_wc", 32'(wc), 32'd3);
    mclk = 1'b1;
    tick();
    tick();
    mclk = 1'b0;
    tick();
    chk("nogame_placing", 32'(placing), 32'd0);
    chk("nogame_wc", 32'(wc), 32'd3);

    // Full-board instance: every wave is capped by MAX_TRIES or the hole count.
    game2 = 1'b1;
    tick();
    maxk = 0;
    popbad = 1'b0;
    downbad = 1'b0;
    zerobad = 1'b0;
    for (int w = 0; w < 300; w++) begin
      mclk2 = 1'b1;
      tick();
      mclk2 = 1'b0;
      cnt2 = 0;
      while (placing2 === 1'b1 && cnt2 < 200) begin
        cnt2++;
        tick();
      end
      if (cnt2 > maxk) maxk = cnt2;
      if (cnt2 == 0) zerobad = 1'b1;
      if ($countones(pos2) > 18 || pos2 == '0) popbad = 1'b1;
      mclk2 = 1'b1;
      tick();
      mclk2 = 1'b0;
      if (pos2 != '0) downbad = 1'b1;
      tick();
    end
    chk("full_max_tries", 32'(maxk <= 64), 32'd1);
    chk("full_cap_reached", 32'(maxk), 32'd64);
    chk("full_every_wave", 32'(zerobad), 32'd0);
    chk("full_pop", 32'(popbad), 32'd0);
    chk("full_down", 32'(downbad), 32'd0);
    chk("wc_saturate", 32'(wc2), 32'd255);

    mclk2 = 1'b1;
    tick();
    mclk2 = 1'b0;
    chk("full_in_place", 32'(placing2), 32'd1);
    #2 rst2 = 1'b1;
    #1;
    chk("async_rst_placing", 32'(placing2), 32'd0);
    chk("async_rst_pos", 32'(pos2), 32'd0);
    chk("async_rst_wc", 32'(wc2), 32'd0);
    rst2 = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sits directly upstream of hit_logic and replaces the placement core behind mole_positions.
- On each mole_clk rising edge during a game it alternates between two actions:
  - placing NUM_MOLES distinct moles at pseudo-random holes;
  - retracting all moles.
- Whacked moles, reported on hit_mask, are removed individually.
- A free-running LFSR drives the randomness. A wave counter reports how many placements have been committed.

Parameters:
- NUM_HOLES, 18, number of holes / width of mole_positions; legal range 2..256.
- NUM_MOLES, 3, moles placed per wave; 1 <= NUM_MOLES <= NUM_HOLES.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- MAX_TRIES, 64, placement attempt cap per wave.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset, asynchronous, active-high.
- game_in_progress  in  1  level from whack_a_mole_fsm; low forces moles down.
- mole_clk  in  1  phase strobe from whack_a_mole_fsm; only rising edges are acted on.
- hit_mask  in  NUM_HOLES  one bit per hole whacked this cycle (from hit_logic).
- mole_positions  out  NUM_HOLES  registered; bit i = mole up in hole i.
- placing  out  1  high while in state PLACE.
- wave_count  out  8  committed waves since reset; saturates at 255.

Behaviour:
- Reset (async, rst=1): all registers cleared, with these exceptions and outputs:
  - lfsr = LFSR_SEED;
  - mole_positions = 0, placing = 0, wave_count = 0;
  - state = IDLE, shadow = 0, placed_cnt = 0, tries = 0, mole_clk_d = 0.
- LFSR: 16-bit Galois, right shift, advances every clk cycle regardless of state.
  - If lfsr[0] = 1: lfsr <= (lfsr >> 1) ^ 16'hB400.
  - Else: lfsr <= lfsr >> 1.
- Candidate hole: cand = lfsr[7:0] mod NUM_HOLES, computed combinationally from the current lfsr.
- Edge detect: edge = mole_clk & ~mole_clk_d, with mole_clk_d registered every cycle.
- State IDLE:
  - game_in_progress = 0: mole_positions <= 0. Edges are ignored. Stay in IDLE.
  - Else if edge and mole_positions != 0 (down phase): mole_positions <= 0 next cycle.
  - Else if edge and mole_positions == 0 (up phase):
    - shadow <= 0, placed_cnt <= 0, tries <= 0;
    - state <= PLACE.
  - Else: mole_positions <= mole_positions & ~hit_mask. Hits on empty holes have no effect.
- State PLACE (placing = 1):
  - Every cycle: tries++.
  - If shadow[cand] = 0: shadow[cand] set and placed_cnt++. Otherwise retry next cycle.
  - Commit when the accepted count reaches NUM_MOLES, or when tries reaches MAX_TRIES (partial wave). On the commit edge:
    - mole_positions <= shadow including this cycle's accept;
    - wave_count++ (saturating);
    - state <= IDLE.
  - mole_clk edges and hit_mask are ignored while in PLACE; mole_positions is 0 throughout PLACE.
  - game_in_progress falling while in PLACE: abort, state <= IDLE, mole_positions stays 0, no wave_count increment.
- Latency: edge sampled high in cycle N; PLACE spans cycles N+1 .. N+k with k >= NUM_MOLES; mole_positions valid from cycle N+k+1.
- Popcount(mole_positions) never exceeds NUM_MOLES. Moles only disappear through hit, down phase, game end, or reset.
- Full clear by hits: positions are 0, so the next edge is an up phase. The next placement therefore starts one phase early, by design.
- Simultaneous edge and hit in IDLE: the edge action takes priority.
  - Down phase: clear all.
  - Up phase: placement starts; the hit is discarded.
- Reset mid-PLACE: immediate return to the reset values above.
- wave_count is not cleared by game_in_progress; only rst clears it.

Test Plan:
- Reset release, game_in_progress = 1, one mole_clk pulse:
  - placing high for >= 3 cycles;
  - then mole_positions has exactly 3 distinct bits set, all below bit 18;
  - wave_count = 1;
  - the result matches a reference model of LFSR_SEED 16'hACE1 bit-for-bit.
- After a placed wave, assert hit_mask = the lowest set bit of mole_positions for one cycle:
  - only that bit clears next cycle; popcount = 2;
  - hit_mask on an empty hole changes nothing.
- Second mole_clk edge with moles up: mole_positions = 0 next cycle. The third edge starts a new PLACE and wave_count = 2.
- Hit all 3 moles, then a mole_clk edge: a new placement starts rather than a down phase. Edge held high for 10 cycles yields exactly one placement.
- Drop game_in_progress in the 2nd PLACE cycle:
  - placing low next cycle;
  - mole_positions = 0 and wave_count unchanged;
  - edges while game_in_progress = 0 are ignored.
- With NUM_MOLES = NUM_HOLES = 18 and MAX_TRIES = 64:
  - commit occurs by the 64th PLACE cycle with popcount <= 18;
  - drive 300 waves: wave_count saturates at 255;
  - assert rst mid-PLACE: all outputs 0 asynchronously.
